// File: rtl/conv_window_gen.sv
// conv_window_gen
//
// Streaming 3x3 window generator. Takes a raster-order stream of 3-bit
// pixels, keeps the two previous image rows in line buffers, and emits one
// packed 27-bit window for every fully populated 3x3 neighbourhood. The
// packing matches the pixel input of the distributed-arithmetic
// inner-product unit.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holds its data stable while
// valid is high and ready is low. in_ready depends only on the output
// register state and out_ready, never on in_valid.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pixel_in    3-bit pixel, raster order, top-left first
//   in_valid    pixel_in is valid
//   in_ready    block can accept a pixel this cycle
//   window_out  packed window, pixel j at bits [3j+2:3j], j = 3*wr + wc,
//               j=0 top-left, j=8 bottom-right
//   out_valid   window_out holds a valid window
//   out_ready   downstream accepts window_out this cycle
//   out_last    final window of the frame (qualified by out_valid)
module conv_window_gen #(
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pixel_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [26:0] window_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // lb1 holds row-1, lb2 holds row-2, both indexed by column.
  // Contents are never reset; emission is gated on row >= 2 of the
  // current frame so stale entries are never visible.
  logic [2:0] lb1_q [IMAGE_WIDTH];
  logic [2:0] lb2_q [IMAGE_WIDTH];

  // 3x3 window register, packed in the output layout.
  logic [26:0] win_q, win_d;

  logic [26:0] window_q, window_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;

  logic       accept;
  logic       emit;
  logic       at_row_end;
  logic       at_frame_end;
  logic [2:0] top_px;
  logic [2:0] mid_px;

  assign in_ready   = !out_valid_q || out_ready;
  assign window_out = window_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

  always_comb begin
    accept       = in_valid && in_ready;
    top_px       = lb2_q[col_q];
    mid_px       = lb1_q[col_q];
    at_row_end   = (col_q == CW'(IMAGE_WIDTH - 1));
    at_frame_end = at_row_end && (row_q == RW'(IMAGE_HEIGHT - 1));
    emit         = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    col_d = col_q;
    row_d = row_q;
    win_d = win_q;

    if (accept) begin
      // Each window row moves one column left; the new right column is
      // (row-2,col), (row-1,col), pixel_in.
      for (int wr = 0; wr < 3; wr++) begin
        win_d[9*wr +: 3]     = win_q[9*wr + 3 +: 3];
        win_d[9*wr + 3 +: 3] = win_q[9*wr + 6 +: 3];
      end
      win_d[6  +: 3] = top_px;
      win_d[15 +: 3] = mid_px;
      win_d[24 +: 3] = pixel_in;

      if (at_row_end) begin
        col_d = '0;
        row_d = at_frame_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // Output register: a new window wins over a drain in the same cycle.
    window_d    = window_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (emit) begin
      window_d    = win_d;
      out_last_d  = at_frame_end;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      window_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      window_q    <= window_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffers: a single read-modify-write at the current column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[col_q] <= mid_px;
      lb1_q[col_q] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
`timescale 1ns/1ps
module tb_conv_window_gen;

  localparam int SW = 5;
  localparam int SH = 4;
  localparam int BW = 256;
  localparam int BH = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance (5x4)
  logic        rst_n_a, iv_a, ir_a, ov_a, ordy_a, last_a;
  logic [2:0]  pix_a;
  logic [26:0] win_a;
  // large instance (256x256)
  logic        rst_n_b, iv_b, ir_b, ov_b, ordy_b, last_b;
  logic [2:0]  pix_b;
  logic [26:0] win_b;

  conv_window_gen #(.IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .pixel_in(pix_a), .in_valid(iv_a),
    .in_ready(ir_a), .window_out(win_a), .out_valid(ov_a),
    .out_ready(ordy_a), .out_last(last_a)
  );

  conv_window_gen #(.IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .pixel_in(pix_b), .in_valid(iv_b),
    .in_ready(ir_b), .window_out(win_b), .out_valid(ov_b),
    .out_ready(ordy_b), .out_last(last_b)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  // Expected entries: {last, window}
  logic [27:0] exp_q0[$];
  logic [27:0] exp_q1[$];
  int          k_cnt[2];
  int          win_cnt[2];
  int          last_cnt[2];
  logic [2:0]  img[2][256][256];
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame is rebuilt as an image; each accepted pixel at
  // (r,c) with r,c >= 2 yields the window of rows r-2..r, cols c-2..c.
  task automatic model_cycle(input int inst, input int w, input int h,
                             input logic rstn, input logic iv, input logic ir,
                             input logic [2:0] px, input logic ov, input logic ordy,
                             input logic [26:0] wo, input logic ol);
    logic [27:0] e;
    logic [26:0] ew;
    int r, c, qs;
    if (!rstn) begin
      k_cnt[inst] = 0;
      if (inst == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    check($sformatf("in_ready%0d", inst), 32'(ir), 32'(!ov || ordy));
    if (ov) begin
      qs = (inst == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid%0d: got out_valid=1 expected no window at %0t", inst, $time);
      end else begin
        e = (inst == 0) ? exp_q0[0] : exp_q1[0];
        check($sformatf("window%0d", inst), 32'(wo), 32'(e[26:0]));
        check($sformatf("last%0d", inst), 32'(ol), 32'(e[27]));
        if (ordy) begin
          if (inst == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
          win_cnt[inst]++;
          if (ol) last_cnt[inst]++;
        end
      end
    end
    if (iv && ir) begin
      r = k_cnt[inst] / w;
      c = k_cnt[inst] % w;
      img[inst][r][c] = px;
      if (r >= 2 && c >= 2) begin
        ew = '0;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            ew[3*(3*wr+wc) +: 3] = img[inst][r-2+wr][c-2+wc];
        e = {(r == h-1 && c == w-1), ew};
        if (inst == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
      k_cnt[inst] = (k_cnt[inst] + 1) % (w*h);
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, SW, SH, rst_n_a, iv_a, ir_a, pix_a, ov_a, ordy_a, win_a, last_a);
    model_cycle(1, BW, BH, rst_n_b, iv_b, ir_b, pix_b, ov_b, ordy_b, win_b, last_b);
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 ordy_a = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input logic [2:0] p, input bit bubbles);
    if (bubbles) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    iv_a  = 1'b1;
    pix_a = p;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir_a) begin
        @(posedge clk);
        #1;
        iv_a = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout_a: got in_ready=0 for 50 cycles expected acceptance");
    iv_a = 1'b0;
  endtask

  // One 5x4 frame; inv selects the 7-(k mod 8) pattern, stall holds
  // out_ready low for 4 cycles after the first window.
  task automatic frame_a(input bit inv, input bit bubbles, input bit stall);
    logic [26:0] first_win;
    first_win = inv ? 27'h3941577 : 27'h46BEA88;
    for (int k = 0; k < SW*SH; k++) begin
      send_a(inv ? 3'(7 - (k % 8)) : 3'(k % 8), bubbles);
      if (k == 11) check("no_window_before_12", 32'(ov_a), 32'd0);
      if (k == 12) begin
        check("first_valid", 32'(ov_a), 32'd1);
        check("first_window", 32'(win_a), 32'(first_win));
        if (stall) begin
          ordy_a = 1'b0;
          repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", 32'(ir_a), 32'd0);
            check("stall_hold", 32'(win_a), 32'(first_win));
            check("stall_valid", 32'(ov_a), 32'd1);
          end
          @(posedge clk);
          #1;
          ordy_a = 1'b1;
        end
      end
    end
  endtask

  task automatic drain_and_count(input string name, input int n_win, input int n_last);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check({name, "_windows"}, 32'(win_cnt[0]), 32'(n_win));
    check({name, "_lasts"}, 32'(last_cnt[0]), 32'(n_last));
    win_cnt[0]  = 0;
    last_cnt[0] = 0;
  endtask

  // ---------------- stimulus ----------------
  task automatic run_small();
    rst_n_a = 1'b0; iv_a = 1'b0; pix_a = '0; ordy_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(ov_a), 32'd0);
    check("reset_ready", 32'(ir_a), 32'd1);
    check("reset_window", 32'(win_a), 32'd0);
    check("reset_last", 32'(last_a), 32'd0);
    rst_n_a = 1'b1;
    win_cnt[0] = 0; last_cnt[0] = 0;

    frame_a(1'b0, 1'b0, 1'b0);
    drain_and_count("basic", 6, 1);

    frame_a(1'b0, 1'b0, 1'b1);
    drain_and_count("backpressure", 6, 1);

    frame_a(1'b0, 1'b1, 1'b0);
    frame_a(1'b0, 1'b1, 1'b0);
    drain_and_count("bubbles", 12, 2);

    frame_a(1'b0, 1'b0, 1'b0);
    frame_a(1'b1, 1'b0, 1'b0);
    drain_and_count("back_to_back", 12, 2);

    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < SW*SH; k++)
        send_a(3'($urandom_range(0, 7)), 1'b1);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ordy_a = 1'b1;
    drain_and_count("random", 18, 3);

    // Reset mid-frame after pixel 9; window_out still holds the last window.
    for (int k = 0; k < 10; k++) send_a(3'(k % 8), 1'b0);
    rst_n_a = 1'b0;
    #1;
    check("midreset_valid", 32'(ov_a), 32'd0);
    check("midreset_ready", 32'(ir_a), 32'd1);
    check("midreset_window", 32'(win_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    win_cnt[0] = 0; last_cnt[0] = 0;
    frame_a(1'b0, 1'b0, 1'b0);
    drain_and_count("after_reset", 6, 1);
  endtask

  task automatic run_big();
    int t;
    rst_n_b = 1'b0; iv_b = 1'b0; pix_b = '0; ordy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n_b = 1'b1;
    win_cnt[1] = 0; last_cnt[1] = 0;
    for (int k = 0; k < BW*BH; k++) begin
      iv_b  = 1'b1;
      pix_b = 3'(((k / BW) + (k % BW)) % 8);
      t = 0;
      @(negedge clk);
      while (!ir_b && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!ir_b) begin
        checks++;
        failures++;
        $display("FAIL send_timeout_b: got in_ready=0 for 50 cycles expected acceptance");
        break;
      end
      @(posedge clk);
      #1;
    end
    iv_b = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("big_windows", 32'(win_cnt[1]), 32'd64516);
    check("big_lasts", 32'(last_cnt[1]), 32'd1);
  endtask

  initial begin
    k_cnt[0] = 0; k_cnt[1] = 0;
    fork
      run_small();
      run_big();
    join
    check("queue_a_empty", 32'(exp_q0.size()), 32'd0);
    check("queue_b_empty", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish within 2ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
